// File: rtl/sn_frame_accum.sv
// Frame accumulator for stochastic bitstreams: counts the 1s over one
// 2^WIDTH-position frame and hands the count out through a one-entry valid/ready register.
module sn_frame_accum #(
   parameter int WIDTH  = 4,
   parameter int STRIDE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [STRIDE-1:0] sn_in,
   input  logic              frame_end,
   output logic [WIDTH:0]    out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun,
   output logic              sat_err
);

   localparam logic [WIDTH+1:0] FULL_SCALE   = (WIDTH+2)'(1) << WIDTH;
   localparam logic [WIDTH:0]   FULL_SCALE_N = (WIDTH+1)'(1) << WIDTH;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH:0]   acc;
   logic [WIDTH+1:0] pc;
   logic [WIDTH+1:0] sum;
   logic [WIDTH:0]   sat_sum;
   logic             close;
   logic             load;
   logic             drop;
   logic             sat_hit;

   always_comb begin
      pc = '0;
      for (int i = 0; i < STRIDE; i++) begin
         pc = pc + {{(WIDTH+1){1'b0}}, sn_in[i]};
      end
   end

   assign sum     = {1'b0, acc} + pc;
   assign sat_sum = (sum >= FULL_SCALE) ? FULL_SCALE_N : sum[WIDTH:0];
   assign close   = en && frame_end;

   // Mid-frame reaching full scale is already an error; at close only exceeding it is.
   assign sat_hit = en && (frame_end ? (sum > FULL_SCALE) : (sum >= FULL_SCALE));

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      drop    = 1'b0;
      case (state_q)
         EMPTY: begin
            if (close) begin
               state_d = FULL;
               load    = 1'b1;
            end
         end
         FULL: begin
            if (close) begin
               state_d = FULL;
               if (out_ready) begin
                  load = 1'b1;
               end else begin
                  drop = 1'b1;
               end
            end else if (out_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (en) begin
         acc <= frame_end ? '0 : sat_sum;
      end
   end

   // On a drop the older result is kept; out_data is never cleared by a transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
      end else if (load) begin
         out_data <= sat_sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
         sat_err <= 1'b0;
      end else begin
         if (drop) begin
            overrun <= 1'b1;
         end
         if (sat_hit) begin
            sat_err <= 1'b1;
         end
      end
   end

   assign out_valid = (state_q == FULL);

endmodule

// File: doc/sn_frame_accum.md
Name: sn_frame_accum

Overview:
- Downstream consumer of the DSC stochastic number generators.
- Counts the 1s in an SN bitstream over one frame of 2^WIDTH bit positions. The frame is delimited by the SNG counter's ctr_overflow.
- Delivers the binary count through a single-entry valid/ready output register.
- Closes the loop SNG -> SC gate (min/max) -> binary, for sweep benches and accuracy checks.

Parameters:
- WIDTH, 4: SNG counter width. Frame length is 2^WIDTH bit positions. Result is WIDTH+1 bits.
- STRIDE, 1: SN bits per cycle. Legal values are 1, 2 and 4, and must match the upstream SNG.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  sample enable. Same signal that drives the upstream SNG en.
- sn_in  in  STRIDE  SN bits for this cycle. All bits belong to the current frame.
- frame_end  in  1  tie to upstream ctr_overflow. High on the cycle carrying the last sn_in bits of a frame.
- out_data  out  WIDTH+1  count of 1s in the completed frame.
- out_valid  out  1  out_data holds an unconsumed result.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.
- overrun  out  1  sticky: a completed frame was dropped because the output register was full.
- sat_err  out  1  sticky: accumulator hit 2^WIDTH before frame_end, or was already at 2^WIDTH and further 1s arrived.

Behaviour:
- Reset (async assert; synchronous-release usage is the integrator's job):
  - acc=0, out_data=0, out_valid=0, overrun=0, sat_err=0.
  - Accumulation starts on the first en cycle after reset. Upstream counter resets on the same rst, so frames are aligned.
- Per cycle with en=1:
  - pc = popcount(sn_in), range 0..STRIDE.
  - sum = acc + pc, computed at WIDTH+2 bits, then saturated to 2^WIDTH.
- en=0: acc, sn_in and frame_end are all ignored. No state changes except the output handshake.
- frame_end=0, en=1:
  - acc <= sat(sum).
  - sat_err <= 1 if sum >= 2^WIDTH, because the frame is not yet complete.
- frame_end=1, en=1 (frame close):
  - final = sat(sum). sat_err <= 1 if sum > 2^WIDTH.
  - acc <= 0. The next cycle's bits start the new frame.
  - If out_valid=0, or out_valid && out_ready in this same cycle: out_data <= final, out_valid <= 1.
  - Otherwise final is discarded, overrun <= 1, and out_data/out_valid are unchanged (the older result wins).
- Latency: out_valid rises the cycle after the frame_end cycle.
- Output handshake:
  - A transfer occurs on a clock edge with out_valid && out_ready.
  - If no new frame closes that cycle, out_valid <= 0. out_data retains its value and is not cleared.
  - out_data is stable while out_valid && !out_ready.
  - out_ready is ignored while out_valid=0.
- overrun and sat_err clear only on rst.
- Reset mid-frame: acc is discarded, no partial result is emitted, and a pending output is lost (out_valid=0).
- Implementation constraints:
  - Two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
    - EMPTY -> FULL on a frame close.
    - FULL -> EMPTY on a transfer with no same-cycle close.
    - FULL -> FULL on close+transfer (reload), or on close without transfer (overrun).
  - Popcount must be a generic loop over STRIDE bits.
  - No combinational path from sn_in, frame_end or out_ready to any output.

Test Plan:
- WIDTH=4, STRIDE=1, sn_in from sng_dsc with bin_in=5, out_ready=1 -> out_data=5, out_valid high 1 cycle after each overflow, repeating every 16 cycles. Check bin_in=0 -> 0 and bin_in=15 -> 15.
- Forced sn_in=1 for 16 en cycles with frame_end on the 16th -> out_data=16, sat_err=0. Then 17 ones before frame_end -> out_data=16, sat_err=1.
- WIDTH=4, STRIDE=4, sng_dsc with bin_in=9 -> frame of 4 cycles, out_data=9. Repeat with STRIDE=2, bin_in=11 -> out_data=11 after 8 cycles.
- Backpressure:
  - out_ready=0 across two frame closes (values 3 then 7) -> out_data stays 3, overrun=1.
  - out_ready=1 asserted on the second close cycle -> out_data=7, overrun=0.
- en toggled 50% with the SNG driven by the same en, bin_in=6 -> out_data=6. Frame takes 32 cycles, and frame_end pulses while en=0 are ignored.
- rst asserted asynchronously mid-frame, with out_valid=1 pending -> all outputs 0 immediately. Next full frame with bin_in=4 -> out_data=4, no stale count.
